// File: rtl/wallace_seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// wallace_seq_mul_pkg : state encoding and nibble width for wallace_seq_mul
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wallace_seq_mul_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wallace_tree.sv
// ---------------------------------------------------------------------------
// wallace_tree : 4x4 unsigned carry-save (Wallace) multiplier, s = x*y
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wallace_tree (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] s,
  output logic       c_8
);

  logic [3:0][8:0] pp;

  for (genvar k = 0; k < 4; k++) begin : g_rows
    assign pp[k] = {5'b0, x & {4{y[k]}}} << k;
  end

  logic [8:0] sum1, car1, sum2, car2, total;

  // Two 3:2 compression levels reduce the four rows to sum/carry vectors.
  assign sum1  = pp[0] ^ pp[1] ^ pp[2];
  assign car1  = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
  assign sum2  = sum1 ^ car1 ^ pp[3];
  assign car2  = ((sum1 & car1) | (sum1 & pp[3]) | (car1 & pp[3])) << 1;
  assign total = sum2 + car2;

  assign s   = total[7:0];
  assign c_8 = total[8];

endmodule

`default_nettype wire

// File: rtl/wallace_seq_mul.sv
// ---------------------------------------------------------------------------
// wallace_seq_mul : N-nibble unsigned multiplier, one 4x4 tree pass per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wallace_seq_mul
  import wallace_seq_mul_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*N-1:0]   a,
  input  logic [4*N-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8*N-1:0]   p,
  output logic             busy,
  output logic             mul_err
);

  localparam int W  = NIB * N;
  localparam int PW = 2 * W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t                  state_q;
  logic [N-1:0][NIB-1:0]   a_q, b_q;
  logic [PW-1:0]           acc_q, acc_d, p_q;
  logic [IW-1:0]           i_q, j_q;
  logic                    in_ready_q, out_valid_q, busy_q, mul_err_q;

  logic [NIB-1:0]          tree_x, tree_y;
  logic [7:0]              tree_s;
  logic                    tree_c8;
  logic [IW+2:0]           shamt;
  logic [PW-1:0]           term;

  // Tree operands come only from the captured registers.
  assign tree_x = a_q[i_q];
  assign tree_y = b_q[j_q];

  wallace_tree u_tree (
    .x   (tree_x),
    .y   (tree_y),
    .s   (tree_s),
    .c_8 (tree_c8)
  );

  assign shamt = {({1'b0, i_q} + {1'b0, j_q}), 2'b00};
  assign term  = PW'(tree_s) << shamt;
  assign acc_d = acc_q + term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_err_q   <= 1'b0;
      p_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
    end else begin
      if (state_q == RUN && tree_c8) begin
        mul_err_q <= 1'b1;
      end

      if (flush) begin
        state_q     <= IDLE;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        acc_q       <= '0;
        i_q         <= '0;
        j_q         <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid) begin
              a_q        <= a;
              b_q        <= b;
              acc_q      <= '0;
              i_q        <= '0;
              j_q        <= '0;
              state_q    <= RUN;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end

          RUN: begin
            if (i_q == LAST && j_q == LAST) begin
              p_q         <= acc_d;
              acc_q       <= '0;
              i_q         <= '0;
              j_q         <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              acc_q <= acc_d;
              if (j_q == LAST) begin
                j_q <= '0;
                i_q <= i_q + IW'(1);
              end else begin
                j_q <= j_q + IW'(1);
              end
            end
          end

          DONE: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end

          default: begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign mul_err   = mul_err_q;
  assign p         = p_q;

endmodule

`default_nettype wire

// File: tb/tb_wallace_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_wallace_seq_mul : directed checks of wallace_seq_mul for N=2 and N=1
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wallace_seq_mul;

  logic clk = 1'b0;
  logic rst_n;

  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2, busy2, err2;
  logic [7:0]  a2, b2;
  logic [15:0] p2;

  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, busy1, err1;
  logic [3:0]  a1, b1;
  logic [7:0]  p1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wallace_seq_mul #(.N(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2),
    .in_ready(in_ready2), .a(a2), .b(b2), .out_valid(out_valid2),
    .out_ready(out_ready2), .p(p2), .busy(busy2), .mul_err(err2)
  );

  wallace_seq_mul #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1),
    .in_ready(in_ready1), .a(a1), .b(b1), .out_valid(out_valid1),
    .out_ready(out_ready1), .p(p1), .busy(busy1), .mul_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run2(input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] ep, input string tag);
    int cnt;
    cnt = 0;
    while (!in_ready2 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    a2 = av; b2 = bv; in_valid2 = 1'b1; out_ready2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    cnt = 0;
    while (!out_valid2 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk({tag, "_lat"}, cnt, 4);
    chk({tag, "_p"}, p2, ep);
    chk({tag, "_err"}, err2, 0);
    @(posedge clk); #1;
    chk({tag, "_ovclr"}, out_valid2, 0);
    chk({tag, "_rdy"}, in_ready2, 1);
  endtask

  task automatic run1(input logic [3:0] av, input logic [3:0] bv,
                      input logic [7:0] ep, input string tag);
    int cnt;
    cnt = 0;
    while (!in_ready1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    a1 = av; b1 = bv; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    cnt = 0;
    while (!out_valid1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk({tag, "_lat"}, cnt, 1);
    chk({tag, "_p"}, p1, ep);
    @(posedge clk); #1;
    chk({tag, "_rdy"}, in_ready1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush2 = 0; in_valid2 = 0; out_ready2 = 1; a2 = 0; b2 = 0;
    flush1 = 0; in_valid1 = 0; out_ready1 = 1; a1 = 0; b1 = 0;
    #12;
    chk("rst_rdy2", in_ready2, 1);
    chk("rst_ov2", out_valid2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_err2", err2, 0);
    chk("rst_p2", p2, 0);
    chk("rst_rdy1", in_ready1, 1);
    chk("rst_p1", p1, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // basic products
    run2(8'h12, 8'h34, 16'h03A8, "t1");
    run2(8'hFF, 8'hFF, 16'hFE01, "t2a");
    run2(8'h00, 8'hA5, 16'h0000, "t2b");

    // backpressure with ignored operand pulses
    a2 = 8'h0F; b2 = 8'h10; in_valid2 = 1; out_ready2 = 0;
    @(posedge clk); #1;
    chk("t3_busy", busy2, 1);
    for (int k = 0; k < 20 && !out_valid2; k++) begin
      in_valid2 = k[0]; a2 = 8'h11; b2 = 8'h11;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 6; k++) begin
      chk("t3_hold_ov", out_valid2, 1);
      chk("t3_hold_p", p2, 16'h00F0);
      chk("t3_hold_rdy", in_ready2, 0);
      in_valid2 = k[0]; a2 = 8'h11; b2 = 8'h11;
      @(posedge clk); #1;
    end
    chk("t3_after_ov", out_valid2, 1);
    in_valid2 = 0; out_ready2 = 1;
    @(posedge clk); #1;
    chk("t3_hs_ov", out_valid2, 0);
    chk("t3_hs_rdy", in_ready2, 1);
    run2(8'h02, 8'h03, 16'h0006, "t3b");

    // asynchronous reset in the second RUN cycle
    a2 = 8'hFF; b2 = 8'hFF; in_valid2 = 1;
    @(posedge clk); #1;
    in_valid2 = 0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_ov", out_valid2, 0);
    chk("t4_p", p2, 0);
    chk("t4_rdy", in_ready2, 1);
    chk("t4_busy", busy2, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run2(8'h03, 8'h05, 16'h000F, "t4b");

    // flush in the third RUN cycle, then flush colliding with in_valid
    a2 = 8'h12; b2 = 8'h34; in_valid2 = 1;
    @(posedge clk); #1;
    in_valid2 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush2 = 1;
    @(posedge clk); #1;
    flush2 = 0;
    chk("t5_busy", busy2, 0);
    chk("t5_rdy", in_ready2, 1);
    chk("t5_ov", out_valid2, 0);
    chk("t5_pkeep", p2, 16'h000F);
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_noov", out_valid2, 0);
    flush2 = 1; in_valid2 = 1; a2 = 8'h77; b2 = 8'h77;
    @(posedge clk); #1;
    flush2 = 0; in_valid2 = 0;
    chk("t5_nocap_busy", busy2, 0);
    chk("t5_nocap_rdy", in_ready2, 1);
    run2(8'h20, 8'h08, 16'h0100, "t5b");

    // N=1 instance: corner then full sweep
    run1(4'hF, 4'hF, 8'hE1, "t6");
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run1(4'(x), 4'(y), 8'(x * y), "sweep");
      end
    end
    chk("t6_err1", err1, 0);
    chk("t6_err2", err2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
